// File: rtl/lif_layer_scheduler_if.sv
// Handshake and data bundle of the LIF layer scheduler.
//   master : drives start/clear, per-timestep input spikes and LIF config
//   slave  : the scheduler; returns busy, done pulse and output spikes
interface lif_layer_scheduler_if #(
  parameter int WIDTH       = 16,
  parameter int NUM_NEURONS = 8
);
  logic                   start;
  logic                   clear;
  logic [NUM_NEURONS-1:0] input_spikes;
  logic [WIDTH-1:0]       leak_factor;
  logic [WIDTH-1:0]       threshold;
  logic [WIDTH-1:0]       reset_value;
  logic                   busy;
  logic                   done;
  logic [NUM_NEURONS-1:0] spikes_out;

  modport master (
    output start, clear, input_spikes, leak_factor, threshold, reset_value,
    input  busy, done, spikes_out
  );

  modport slave (
    input  start, clear, input_spikes, leak_factor, threshold, reset_value,
    output busy, done, spikes_out
  );
endinterface

// File: rtl/lif_layer_scheduler.sv
// Time-multiplexed leaky integrate-and-fire layer: one shared update
// datapath walks NUM_NEURONS potentials, one neuron per clock, per timestep.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   sched : slave side of lif_layer_scheduler_if (start/clear, spikes in,
//           leak/threshold/reset config, busy/done/spikes_out)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting; clear zeroes potentials, start latches inputs/config
// S_UPDATE | neuron idx_q leaked, integrated and fired this cycle
// S_DONE   | one cycle; done high, spikes_out holds the new timestep
module lif_layer_scheduler #(
  parameter int WIDTH       = 16,
  parameter int FRACTIONAL  = 8,
  parameter int NUM_NEURONS = 8
) (
  input logic                  clk,
  input logic                  rst,
  lif_layer_scheduler_if.slave sched
);
  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
  localparam logic [WIDTH:0]   SPIKE_INC = {{WIDTH{1'b0}}, 1'b1} << FRACTIONAL;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WIDTH-1:0]       pot_q [NUM_NEURONS];
  logic [WIDTH-1:0]       pot_d [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] spk_in_q, spk_in_d;
  logic [WIDTH-1:0]       leak_q, leak_d;
  logic [WIDTH-1:0]       thr_q, thr_d;
  logic [WIDTH-1:0]       rst_val_q, rst_val_d;
  logic [NUM_NEURONS-1:0] acc_q, acc_d;
  logic [NUM_NEURONS-1:0] spikes_out_q, spikes_out_d;

  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       leaked;
  logic [WIDTH:0]         sum_raw;
  logic [WIDTH-1:0]       sum_sat;
  logic                   fire;

  // Shared datapath for the neuron selected by idx_q. An integer part that
  // overflows WIDTH after the fractional shift saturates instead of
  // wrapping, so a gain > 1.0 pins the potential at full scale.
  always_comb begin
    prod    = {{WIDTH{1'b0}}, pot_q[idx_q]} * {{WIDTH{1'b0}}, leak_q};
    leaked  = (|prod[2*WIDTH-1:WIDTH+FRACTIONAL]) ? '1
                                                   : prod[WIDTH+FRACTIONAL-1:FRACTIONAL];
    sum_raw = {1'b0, leaked} + (spk_in_q[idx_q] ? SPIKE_INC : '0);
    sum_sat = sum_raw[WIDTH] ? '1 : sum_raw[WIDTH-1:0];
    fire    = (sum_sat >= thr_q);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pot_d        = pot_q;
    spk_in_d     = spk_in_q;
    leak_d       = leak_q;
    thr_d        = thr_q;
    rst_val_d    = rst_val_q;
    acc_d        = acc_q;
    spikes_out_d = spikes_out_q;
    case (state_q)
      S_IDLE: begin
        // clear and start together: the timestep starts from zero potentials
        if (sched.clear) begin
          for (int i = 0; i < NUM_NEURONS; i++) pot_d[i] = '0;
        end
        if (sched.start) begin
          state_d   = S_UPDATE;
          idx_d     = '0;
          acc_d     = '0;
          spk_in_d  = sched.input_spikes;
          leak_d    = sched.leak_factor;
          thr_d     = sched.threshold;
          rst_val_d = sched.reset_value;
        end
      end
      S_UPDATE: begin
        pot_d[idx_q] = fire ? rst_val_q : sum_sat;
        acc_d[idx_q] = fire;
        if (idx_q == LAST_IDX) begin
          state_d      = S_DONE;
          idx_d        = '0;
          spikes_out_d = acc_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) pot_q[i] <= '0;
      spk_in_q     <= '0;
      leak_q       <= '0;
      thr_q        <= '0;
      rst_val_q    <= '0;
      acc_q        <= '0;
      spikes_out_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pot_q        <= pot_d;
      spk_in_q     <= spk_in_d;
      leak_q       <= leak_d;
      thr_q        <= thr_d;
      rst_val_q    <= rst_val_d;
      acc_q        <= acc_d;
      spikes_out_q <= spikes_out_d;
    end
  end

  assign sched.busy       = (state_q != S_IDLE);
  assign sched.done       = (state_q == S_DONE);
  assign sched.spikes_out = spikes_out_q;
endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Directed bench for lif_layer_scheduler: hand-computed potentials and
// spike patterns per timestep, timing of busy/done, reset and clear cases.
module tb_lif_layer_scheduler;
  localparam int W = 16;
  localparam int F = 8;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lif_layer_scheduler_if #(.WIDTH(W), .NUM_NEURONS(N)) sched ();

  lif_layer_scheduler #(.WIDTH(W), .FRACTIONAL(F), .NUM_NEURONS(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .sched(sched.slave)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_clear();
    @(negedge clk);
    sched.clear = 1'b1;
    @(negedge clk);
    sched.clear = 1'b0;
  endtask

  // One timestep; inputs are scrambled once started to show they are latched.
  task automatic run_step(input logic [N-1:0] spk, input logic [W-1:0] leak,
                          input logic [W-1:0] thr, input logic [W-1:0] rv,
                          input bit clr, output logic [N-1:0] so);
    bit seen;
    @(negedge clk);
    sched.input_spikes = spk;
    sched.leak_factor  = leak;
    sched.threshold    = thr;
    sched.reset_value  = rv;
    sched.clear        = clr;
    sched.start        = 1'b1;
    @(negedge clk);
    sched.start        = 1'b0;
    sched.clear        = 1'b0;
    sched.input_spikes = ~spk;
    sched.leak_factor  = leak ^ 16'h5A5A;
    sched.threshold    = ~thr;
    sched.reset_value  = ~rv;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (sched.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    so = sched.spikes_out;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL step_done_timeout: done=%b required 1 within 20 cycles", sched.done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sched.start = 1'b0;
    sched.clear = 1'b0;
    sched.input_spikes = '0;
    sched.leak_factor = '0;
    sched.threshold = '0;
    sched.reset_value = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (sched.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", sched.busy); end
    tests++;
    if (sched.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", sched.done); end
    tests++;
    if (sched.spikes_out !== 8'h00) begin fails++; $display("FAIL reset_spikes: got %h want 00", sched.spikes_out); end
    tests++;
    if (dut.pot_q[0] !== 16'h0000) begin fails++; $display("FAIL reset_pot0: got %h want 0000", dut.pot_q[0]); end
    rst = 1'b0;
  endtask

  task automatic test_timing();
    logic exp_busy, exp_done;
    sched.input_spikes = '0;
    sched.leak_factor = '0;
    sched.threshold = 16'hFFFF;
    sched.reset_value = '0;
    @(negedge clk);
    sched.start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      sched.start = (k >= 2 && k <= 5);
      exp_busy = (k <= 9);
      exp_done = (k == 9);
      tests++;
      if (sched.busy !== exp_busy) begin
        fails++; $display("FAIL timing_busy k=%0d: got %b want %b", k, sched.busy, exp_busy);
      end
      tests++;
      if (sched.done !== exp_done) begin
        fails++; $display("FAIL timing_done k=%0d: got %b want %b", k, sched.done, exp_done);
      end
    end
  endtask

  task automatic test_zero_cases();
    logic [N-1:0] so;
    do_clear();
    run_step(8'h00, 16'h0100, 16'h0000, 16'h0040, 1'b0, so);
    tests++;
    if (so !== 8'hFF) begin fails++; $display("FAIL thr0_spikes: got %h want ff", so); end
    tests++;
    if (dut.pot_q[3] !== 16'h0040) begin fails++; $display("FAIL thr0_pot3: got %h want 0040", dut.pot_q[3]); end
    run_step(8'h01, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, so);
    tests++;
    if (dut.pot_q[0] !== 16'h0100) begin fails++; $display("FAIL leak0_pot0: got %h want 0100", dut.pot_q[0]); end
    tests++;
    if (dut.pot_q[1] !== 16'h0000) begin fails++; $display("FAIL leak0_pot1: got %h want 0000", dut.pot_q[1]); end
    tests++;
    if (so !== 8'h00) begin fails++; $display("FAIL leak0_spikes: got %h want 00", so); end
  endtask

  task automatic test_leak_sequence();
    logic [W-1:0] exp_pot [4] = '{16'h0100, 16'h01E6, 16'h02B4, 16'h0080};
    logic [N-1:0] exp_so  [4] = '{8'h00, 8'h00, 8'h00, 8'h01};
    logic [N-1:0] so;
    do_clear();
    for (int s = 0; s < 4; s++) begin
      run_step(8'h01, 16'h00E6, 16'h0300, 16'h0080, 1'b0, so);
      tests++;
      if (dut.pot_q[0] !== exp_pot[s]) begin
        fails++; $display("FAIL leak_pot0 step=%0d: got %h want %h", s + 1, dut.pot_q[0], exp_pot[s]);
      end
      tests++;
      if (so !== exp_so[s]) begin
        fails++; $display("FAIL leak_spikes step=%0d: got %h want %h", s + 1, so, exp_so[s]);
      end
    end
    tests++;
    if (dut.pot_q[5] !== 16'h0000) begin fails++; $display("FAIL leak_pot5: got %h want 0000", dut.pot_q[5]); end
  endtask

  task automatic test_all_fire();
    logic [N-1:0] so;
    do_clear();
    run_step(8'hFF, 16'h00E6, 16'h0100, 16'h0055, 1'b0, so);
    tests++;
    if (so !== 8'hFF) begin fails++; $display("FAIL allfire_spikes: got %h want ff", so); end
    tests++;
    if (dut.pot_q[0] !== 16'h0055) begin fails++; $display("FAIL allfire_pot0: got %h want 0055", dut.pot_q[0]); end
    tests++;
    if (dut.pot_q[7] !== 16'h0055) begin fails++; $display("FAIL allfire_pot7: got %h want 0055", dut.pot_q[7]); end
  endtask

  task automatic test_saturation();
    logic [W-1:0] exp_pot [9] = '{16'h0100, 16'h0300, 16'h0700, 16'h0F00, 16'h1F00,
                                  16'h3F00, 16'h7F00, 16'hFF00, 16'h0010};
    logic [N-1:0] so;
    logic         exp_fire;
    do_clear();
    for (int s = 0; s < 9; s++) begin
      run_step(8'h01, 16'h0200, 16'hFFFF, 16'h0010, 1'b0, so);
      exp_fire = (s == 8);
      tests++;
      if (so[0] !== exp_fire) begin
        fails++; $display("FAIL sat_spike step=%0d: got %b want %b", s + 1, so[0], exp_fire);
      end
      tests++;
      if (dut.pot_q[0] !== exp_pot[s]) begin
        fails++; $display("FAIL sat_pot0 step=%0d: got %h want %h", s + 1, dut.pot_q[0], exp_pot[s]);
      end
    end
  endtask

  task automatic test_reset_mid_update();
    logic [N-1:0] so;
    bit           done_seen;
    run_step(8'h00, 16'h0000, 16'h0000, 16'h0080, 1'b0, so);
    tests++;
    if (so !== 8'hFF) begin fails++; $display("FAIL rstmid_pre_spikes: got %h want ff", so); end
    @(negedge clk);
    sched.start = 1'b1;
    @(negedge clk);
    sched.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (sched.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", sched.busy); end
    tests++;
    if (sched.spikes_out !== 8'h00) begin fails++; $display("FAIL rstmid_spikes: got %h want 00", sched.spikes_out); end
    tests++;
    if (dut.pot_q[6] !== 16'h0000) begin fails++; $display("FAIL rstmid_pot6: got %h want 0000", dut.pot_q[6]); end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (sched.done === 1'b1) done_seen = 1'b1;
    end
    tests++;
    if (done_seen) begin fails++; $display("FAIL rstmid_no_done: got done pulse want none"); end
    run_step(8'h01, 16'h00E6, 16'h0300, 16'h0080, 1'b0, so);
    tests++;
    if (dut.pot_q[0] !== 16'h0100) begin fails++; $display("FAIL rstmid_pot0: got %h want 0100", dut.pot_q[0]); end
    tests++;
    if (dut.pot_q[1] !== 16'h0000) begin fails++; $display("FAIL rstmid_pot1: got %h want 0000", dut.pot_q[1]); end
  endtask

  task automatic test_clear_start();
    logic [N-1:0] so;
    do_clear();
    run_step(8'hFF, 16'h0100, 16'hFFFF, 16'h0000, 1'b0, so);
    // second step with a clear pulse while busy, which must be ignored
    @(negedge clk);
    sched.input_spikes = 8'hFF;
    sched.leak_factor = 16'h0100;
    sched.threshold = 16'hFFFF;
    sched.start = 1'b1;
    @(negedge clk);
    sched.start = 1'b0;
    repeat (2) @(negedge clk);
    sched.clear = 1'b1;
    @(negedge clk);
    sched.clear = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (dut.pot_q[0] !== 16'h0200) begin fails++; $display("FAIL clrbusy_pot0: got %h want 0200", dut.pot_q[0]); end
    tests++;
    if (dut.pot_q[7] !== 16'h0200) begin fails++; $display("FAIL clrbusy_pot7: got %h want 0200", dut.pot_q[7]); end
    run_step(8'h0F, 16'h0100, 16'h0180, 16'h0000, 1'b1, so);
    tests++;
    if (so !== 8'h00) begin fails++; $display("FAIL clrstart_spikes: got %h want 00", so); end
    tests++;
    if (dut.pot_q[0] !== 16'h0100) begin fails++; $display("FAIL clrstart_pot0: got %h want 0100", dut.pot_q[0]); end
    tests++;
    if (dut.pot_q[4] !== 16'h0000) begin fails++; $display("FAIL clrstart_pot4: got %h want 0000", dut.pot_q[4]); end
  endtask

  task automatic test_back_to_back();
    int  first, second, cyc;
    first = -1;
    second = -1;
    sched.input_spikes = '0;
    sched.leak_factor = '0;
    sched.threshold = 16'hFFFF;
    @(negedge clk);
    sched.start = 1'b1;
    for (cyc = 0; cyc < 40 && second < 0; cyc++) begin
      @(negedge clk);
      if (sched.done === 1'b1) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    sched.start = 1'b0;
    tests++;
    if (first < 0 || second < 0 || (second - first) != N + 2) begin
      fails++; $display("FAIL b2b_period: got %0d want %0d", second - first, N + 2);
    end
    for (int k = 0; k < 20 && sched.busy === 1'b1; k++) @(negedge clk);
    tests++;
    if (sched.busy !== 1'b0) begin fails++; $display("FAIL b2b_drain: busy=%b want 0", sched.busy); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_zero_cases();
    test_leak_sequence();
    test_all_fire();
    test_saturation();
    test_reset_mid_update();
    test_clear_start();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lif_layer_scheduler.md
LIF_LAYER_SCHEDULER -- requirements
Module: lif_layer_scheduler

Interface
REQ-001 Parameter WIDTH, 16, fixed-point word width of potentials and config values, unsigned.
REQ-002 Parameter FRACTIONAL, 8, fractional bits of the unsigned fixed-point format.
REQ-003 Parameter NUM_NEURONS, 8, number of neurons time-multiplexed onto one LIF update datapath (>=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to process one timestep; accepted only in IDLE.
REQ-007 clear  input  1  zero all potentials; honoured only in IDLE.
REQ-008 input_spikes  input  NUM_NEURONS  per-neuron input spike for the timestep, sampled on start acceptance.
REQ-009 leak_factor, threshold, reset_value  input  WIDTH each  LIF config, sampled on start acceptance.
REQ-010 busy  output  1  high in UPDATE and DONE states.
REQ-011 done  output  1  one-cycle pulse when spikes_out is valid.
REQ-012 spikes_out  output  NUM_NEURONS  per-neuron output spikes of the last completed timestep.

Function
REQ-013 FSM states IDLE, UPDATE, DONE; IDLE+start -> UPDATE; UPDATE with index==NUM_NEURONS-1 -> DONE; DONE -> IDLE unconditionally.
REQ-014 Start acceptance at cycle t: latch input_spikes and config, clear index to 0, clear internal spike accumulator.
REQ-015 Neuron i updated at edge t+1+i; exactly one neuron per cycle; index increments by 1 per UPDATE cycle.
REQ-016 Update: leaked = (potential[i] * leak_factor) >> FRACTIONAL, product computed at 2*WIDTH bits, then truncated.
REQ-017 Integrate: sum = leaked + (latched spike[i] ? 1<<FRACTIONAL : 0), computed at WIDTH+1 bits, saturated to 2^WIDTH-1.
REQ-018 Fire: sum >= threshold -> spike bit i = 1, potential[i] <= reset_value; else spike bit i = 0, potential[i] <= sum.
REQ-019 spikes_out and done asserted in the DONE cycle (edge t+NUM_NEURONS+1); done low otherwise; spikes_out holds until next DONE.
REQ-020 start while busy ignored, not queued; config/input changes while busy have no effect on the running timestep.
REQ-021 start and clear simultaneously in IDLE: clear applied first (potentials zeroed), timestep begins next cycle with all potentials 0.
REQ-022 clear while busy ignored.
REQ-023 threshold = 0 -> every neuron fires every timestep; leak_factor = 0 -> leaked term 0.
REQ-024 Back-to-back timesteps: start held high gives a new acceptance in the IDLE cycle after DONE (period NUM_NEURONS+2).

Reset
REQ-025 rst asserted: state IDLE, index 0, all potentials 0, busy 0, done 0, spikes_out 0, latched config/inputs 0, immediately and independent of clk.
REQ-026 rst mid-UPDATE aborts the timestep; no done pulse; partial potential updates discarded (all potentials 0).

Verification
REQ-027 leak 0x00E6, threshold 0x0300, reset 0x0080, input_spikes bit0=1 for 4 timesteps -> neuron0 potential 0x0100, 0x01E6, 0x02B4, then spike in timestep 4 with potential 0x0080; other neurons stay 0, no spike.
REQ-028 Single start with NUM_NEURONS=8 -> busy high for 9 cycles, done exactly at edge t+9 for one cycle, start pulses during busy produce no extra done.
REQ-029 threshold 0x0100, input_spikes 0xFF, potentials 0 -> spikes_out 0xFF in first timestep, all potentials = reset_value.
REQ-030 leak_factor 0x0200 (2.0), input spike every timestep -> potential saturates at 0xFFFF with threshold 0xFFFF, spikes; no wrap to small values.
REQ-031 rst pulsed at index 3 of UPDATE -> busy/done/spikes_out 0 asynchronously, next timestep starts from zero potentials.
REQ-032 clear and start same cycle after potentials nonzero -> timestep results equal those from zero potentials.
